// File: rtl/game_stat_ctrl.sv
// Game-session controller: restart debouncer, IDLE/PLAY/DEAD sequencing, BCD game/score/best
// counters and death LED blinker. Every output comes straight from a register.
module game_stat_ctrl #(
  parameter int DIGITS       = 4,
  parameter int DEB_CYCLES   = 500000,
  parameter int BLINK_CYCLES = 25000000,
  parameter int LED_W        = 8
) (
  input  logic                clk,
  input  logic                clrn,
  input  logic                btn_restart,
  input  logic                death,
  input  logic                pass_pulse,
  output logic [1:0]          state,
  output logic                restart_pulse,
  output logic [4*DIGITS-1:0] game_cnt,
  output logic [4*DIGITS-1:0] score,
  output logic [4*DIGITS-1:0] best,
  output logic                new_best,
  output logic [LED_W-1:0]    led
);

  localparam int CW      = 4 * DIGITS;
  localparam int DEB_W   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_PLAY = 2'b01,
    S_DEAD = 2'b10
  } state_e;

  // BCD increment with per-digit carry; all-9s is a fixed point so counters never wrap.
  function automatic logic [CW-1:0] bcd_inc(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    logic          carry;
    r     = v;
    carry = 1'b1;
    if (v != {DIGITS{4'h9}}) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (carry) begin
          if (v[4*i +: 4] == 4'h9) begin
            r[4*i +: 4] = 4'h0;
          end else begin
            r[4*i +: 4] = v[4*i +: 4] + 4'h1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  // Strict BCD magnitude compare, most significant digit decides first.
  function automatic logic bcd_gt(input logic [CW-1:0] a, input logic [CW-1:0] b);
    logic gt;
    logic decided;
    gt      = 1'b0;
    decided = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (!decided && (a[4*i +: 4] != b[4*i +: 4])) begin
        gt      = (a[4*i +: 4] > b[4*i +: 4]);
        decided = 1'b1;
      end
    end
    return gt;
  endfunction

  // Restart button: synchroniser and debouncer
  logic             sync1_q, sync2_q;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             deb_lvl_q, deb_lvl_d;
  logic             deb_prev_q;
  logic             press;

  always_ff @(posedge clk or negedge clrn) begin
    // NOTE: sequential state is updated only with non-blocking assignments so every
    // register samples pre-edge values regardless of process ordering.
    if (!clrn) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      deb_cnt_q  <= '0;
      deb_lvl_q  <= 1'b0;
      deb_prev_q <= 1'b0;
    end else begin
      sync1_q    <= btn_restart;
      sync2_q    <= sync1_q;
      deb_cnt_q  <= deb_cnt_d;
      deb_lvl_q  <= deb_lvl_d;
      deb_prev_q <= deb_lvl_q;
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    deb_cnt_d = '0;
    deb_lvl_d = deb_lvl_q;
    if (sync2_q != deb_lvl_q) begin
      if (deb_cnt_q == DEB_W'(DEB_CYCLES - 1)) begin
        deb_lvl_d = sync2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + DEB_W'(1);
      end
    end
  end

  assign press = deb_lvl_q & ~deb_prev_q;

  // Session state and counters
  state_e             state_q, state_d;
  logic [CW-1:0]      game_q, game_d;
  logic [CW-1:0]      score_q, score_d;
  logic [CW-1:0]      best_q, best_d;
  logic               new_best_q, new_best_d;
  logic               restart_q, restart_d;
  logic [LED_W-1:0]   led_q, led_d;
  logic [BLINK_W-1:0] blink_q, blink_d;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q    <= S_IDLE;
      game_q     <= '0;
      score_q    <= '0;
      best_q     <= '0;
      new_best_q <= 1'b0;
      restart_q  <= 1'b0;
      led_q      <= '0;
      blink_q    <= '0;
    end else begin
      state_q    <= state_d;
      game_q     <= game_d;
      score_q    <= score_d;
      best_q     <= best_d;
      new_best_q <= new_best_d;
      restart_q  <= restart_d;
      led_q      <= led_d;
      blink_q    <= blink_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    game_d     = game_q;
    score_d    = score_q;
    best_d     = best_q;
    new_best_d = new_best_q;
    restart_d  = 1'b0;
    led_d      = led_q;
    blink_d    = blink_q;

    // A press overrides whatever the engine reports in the same cycle.
    if (press) begin
      state_d    = S_PLAY;
      score_d    = '0;
      game_d     = bcd_inc(game_q);
      restart_d  = 1'b1;
      new_best_d = 1'b0;
      led_d      = '0;
      blink_d    = '0;
    end else begin
      case (state_q)
        S_PLAY: begin
          if (pass_pulse) begin
            score_d = bcd_inc(score_q);
          end
          // Best compare sees the score including a pass in the same cycle.
          if (death) begin
            state_d = S_DEAD;
            led_d   = '1;
            blink_d = '0;
            if (bcd_gt(score_d, best_q)) begin
              best_d     = score_d;
              new_best_d = 1'b1;
            end else begin
              new_best_d = 1'b0;
            end
          end
        end
        S_DEAD: begin
          if (blink_q == BLINK_W'(BLINK_CYCLES - 1)) begin
            blink_d = '0;
            led_d   = ~led_q;
          end else begin
            blink_d = blink_q + BLINK_W'(1);
          end
        end
        default: begin
          // IDLE, and recovery from the unused encoding.
          state_d = S_IDLE;
          led_d   = '0;
          blink_d = '0;
        end
      endcase
    end
  end

  assign state         = state_q;
  assign restart_pulse = restart_q;
  assign game_cnt      = game_q;
  assign score         = score_q;
  assign best          = best_q;
  assign new_best      = new_best_q;
  assign led           = led_q;

endmodule

// File: tb/tb_game_stat_ctrl.sv
// Self-checking bench for game_stat_ctrl: an integer-level session model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_game_stat_ctrl;

  localparam int DIGITS = 2;
  localparam int DEB    = 4;
  localparam int BLINK  = 8;
  localparam int LED_W  = 8;
  localparam int MAXV   = 99;

  logic                clk;
  logic                clrn;
  logic                btn_restart;
  logic                death;
  logic                pass_pulse;
  logic [1:0]          state;
  logic                restart_pulse;
  logic [4*DIGITS-1:0] game_cnt;
  logic [4*DIGITS-1:0] score;
  logic [4*DIGITS-1:0] best;
  logic                new_best;
  logic [LED_W-1:0]    led;

  game_stat_ctrl #(
    .DIGITS      (DIGITS),
    .DEB_CYCLES  (DEB),
    .BLINK_CYCLES(BLINK),
    .LED_W       (LED_W)
  ) dut (
    .clk          (clk),
    .clrn         (clrn),
    .btn_restart  (btn_restart),
    .death        (death),
    .pass_pulse   (pass_pulse),
    .state        (state),
    .restart_pulse(restart_pulse),
    .game_cnt     (game_cnt),
    .score        (score),
    .best         (best),
    .new_best     (new_best),
    .led          (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int pulses = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
    logic [4*DIGITS-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Behavioural model: decimal counters, a raw-sample history for the debouncer,
  // and a count of cycles spent dead for the blinker.
  int   m_state, m_score, m_game, m_best, m_dead_cyc;
  bit   m_new_best, m_restart, m_lvl, m_press_pend;
  logic raw_q[$];

  task automatic model_reset();
    m_state = 0; m_score = 0; m_game = 0; m_best = 0; m_dead_cyc = 0;
    m_new_best = 0; m_restart = 0; m_lvl = 0; m_press_pend = 0;
    raw_q.delete();
    for (int i = 0; i < DEB + 2; i++) raw_q.push_back(1'b0);
  endtask

  always @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      model_reset();
    end else begin
      bit press_now;
      bit all_flip;
      press_now = m_press_pend;
      m_restart = 0;
      if (press_now) begin
        m_state    = 1;
        m_score    = 0;
        m_game     = (m_game < MAXV) ? m_game + 1 : MAXV;
        m_restart  = 1;
        m_new_best = 0;
      end else if (m_state == 1) begin
        if (pass_pulse) m_score = (m_score < MAXV) ? m_score + 1 : MAXV;
        if (death) begin
          m_state    = 2;
          m_dead_cyc = 0;
          m_new_best = (m_score > m_best);
          if (m_new_best) m_best = m_score;
        end
      end else if (m_state == 2) begin
        m_dead_cyc++;
      end
      // Raw samples two edges old are what the debouncer sees; DEB of them in a row
      // opposite the current level flip it, and a rise is a press one edge later.
      raw_q.push_front(btn_restart);
      all_flip = 1;
      for (int i = 2; i < DEB + 2; i++) if (raw_q[i] == m_lvl) all_flip = 0;
      raw_q.pop_back();
      m_press_pend = 0;
      if (all_flip) begin
        m_lvl        = ~m_lvl;
        m_press_pend = m_lvl;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [LED_W-1:0] exp_led;
      exp_led = '0;
      if (m_state == 2 && ((m_dead_cyc / BLINK) % 2) == 0) exp_led = '1;
      check("state",    32'(state),         32'(m_state));
      check("restart",  32'(restart_pulse), 32'(m_restart));
      check("game_cnt", 32'(game_cnt),      32'(to_bcd(m_game)));
      check("score",    32'(score),         32'(to_bcd(m_score)));
      check("best",     32'(best),          32'(to_bcd(m_best)));
      check("new_best", 32'(new_best),      32'(m_new_best));
      check("led",      32'(led),           32'(exp_led));
      if (restart_pulse) pulses++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press_clean();
    btn_restart = 1'b1;
    repeat (DEB + 6) tick();
    btn_restart = 1'b0;
    repeat (DEB + 6) tick();
  endtask

  task automatic passes(input int n);
    pass_pulse = 1'b1;
    repeat (n) tick();
    pass_pulse = 1'b0;
  endtask

  task automatic die();
    death = 1'b1;
    tick();
    death = 1'b0;
  endtask

  task automatic do_reset();
    clrn = 1'b0;
    tick();
    clrn = 1'b1;
    tick();
  endtask

  initial begin
    clrn = 1'b0; btn_restart = 1'b0; death = 1'b0; pass_pulse = 1'b0;
    repeat (3) tick();
    clrn = 1'b1;
    chk_en = 1'b1;
    tick();
    check("rst_state", 32'(state), 32'h0);
    check("rst_game",  32'(game_cnt), 32'h0);
    check("rst_led",   32'(led), 32'h0);

    // 1: bouncing press, then bouncing release
    for (int i = 0; i < 10; i++) begin
      btn_restart = ~btn_restart;
      tick(); tick();
    end
    btn_restart = 1'b1;
    repeat (12) tick();
    check("t1_pulses", 32'(pulses), 32'd1);
    check("t1_game",   32'(game_cnt), 32'h01);
    check("t1_state",  32'(state), 32'h1);
    for (int i = 0; i < 10; i++) begin
      btn_restart = ~btn_restart;
      tick(); tick();
    end
    btn_restart = 1'b0;
    repeat (12) tick();
    check("t1_pulses_rel", 32'(pulses), 32'd1);

    // 2: scoring, death, blink
    passes(12);
    check("t2_score", 32'(score), 32'h12);
    die();
    check("t2_state", 32'(state), 32'h2);
    check("t2_best",  32'(best), 32'h12);
    check("t2_nb",    32'(new_best), 32'h1);
    check("t2_led0",  32'(led), 32'hFF);
    repeat (7) tick();
    check("t2_led7",  32'(led), 32'hFF);
    tick();
    check("t2_led8",  32'(led), 32'h00);
    repeat (8) tick();
    check("t2_led16", 32'(led), 32'hFF);

    // 3: equal score leaves best, higher score replaces it
    press_clean();
    check("t3_score0", 32'(score), 32'h0);
    passes(12);
    die();
    check("t3_best_eq", 32'(best), 32'h12);
    check("t3_nb_eq",   32'(new_best), 32'h0);
    press_clean();
    passes(13);
    die();
    check("t3_best_hi", 32'(best), 32'h13);
    check("t3_nb_hi",   32'(new_best), 32'h1);

    // press lands in the same cycle as death and pass: press wins
    press_clean();
    passes(3);
    btn_restart = 1'b1;
    repeat (6) tick();
    death = 1'b1; pass_pulse = 1'b1;
    tick();
    death = 1'b0; pass_pulse = 1'b0;
    check("pw_state", 32'(state), 32'h1);
    check("pw_score", 32'(score), 32'h0);
    btn_restart = 1'b0;
    repeat (10) tick();

    // 4: simultaneous pass and death
    do_reset();
    press_clean();
    passes(9);
    pass_pulse = 1'b1; death = 1'b1;
    tick();
    pass_pulse = 1'b0; death = 1'b0;
    check("t4_score", 32'(score), 32'h10);
    check("t4_state", 32'(state), 32'h2);
    check("t4_best",  32'(best), 32'h10);

    // 5: saturation of score and game count
    press_clean();
    passes(105);
    check("t5_score", 32'(score), 32'h99);
    for (int i = 0; i < 100; i++) press_clean();
    check("t5_game", 32'(game_cnt), 32'h99);

    // 6: reset mid-game, then engine activity in IDLE
    do_reset();
    press_clean();
    passes(7);
    die();
    press_clean();
    passes(5);
    check("t6_score_pre", 32'(score), 32'h05);
    check("t6_best_pre",  32'(best), 32'h07);
    clrn = 1'b0;
    tick();
    check("t6_rst_score", 32'(score), 32'h0);
    check("t6_rst_best",  32'(best), 32'h0);
    check("t6_rst_game",  32'(game_cnt), 32'h0);
    clrn = 1'b1;
    pass_pulse = 1'b1; death = 1'b1;
    repeat (5) tick();
    pass_pulse = 1'b0; death = 1'b0;
    tick();
    check("t6_idle_state", 32'(state), 32'h0);
    check("t6_idle_score", 32'(score), 32'h0);
    check("t6_idle_led",   32'(led), 32'h0);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
